rr_arb: RTL and testbench
=========================

# rr_arb

Round-robin arbiter that selects one of N requesters and drives a one-hot grant directly into the select input of the downstream one-hot AND-OR `mux`. Grant is combinational from the current request vector but is held stable across back-pressure and can be locked across multi-beat transfers. A registered priority pointer guarantees starvation freedom.

## Interface
- `N`, default 4: number of requesters; legal range 1..32.
- `W_ENC`, default `(N > 1) ? $clog2(N) : 1`: width of the encoded grant; derived, not overridden.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `arst_n`  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to `clk` externally.
- `i_req`  in  N  per-requester request; once asserted, a requester holds it until granted and acked.
- `i_lock`  in  1  sampled with `i_ack`; when high, the current winner keeps the grant for the next beat.
- `i_ack`  in  1  downstream accepts the granted beat this cycle.
- `o_valid`  out  1  a grant is presented this cycle.
- `o_gnt`  out  N  one-hot grant, connects to `mux` `i_sel`; all-zero when `o_valid` is 0.
- `o_gnt_enc`  out  W_ENC  binary index of the granted requester; 0 when `o_valid` is 0.

## Operation
- State: `ptr_r` (W_ENC bits, index of highest-priority requester), `held_r` (1 bit), `held_gnt_r` (N bits, one-hot).
- Reset values: `ptr_r`=0, `held_r`=0, `held_gnt_r`=0. With `i_req`=0 the outputs are `o_valid`=0, `o_gnt`=0, `o_gnt_enc`=0.
- Arbitration, when `held_r`=0:
  - Scan `i_req` starting at index `ptr_r`, ascending, wrapping from N-1 to 0.
  - The first set bit wins.
  - `o_valid` = |`i_req`.
- Hold, when `held_r`=1:
  - `o_gnt` = `held_gnt_r` and `o_valid`=1, independent of `i_req`.
  - New or higher-priority requests do not preempt.
- State update each cycle when `o_valid`=1:
  - `i_ack`=0: `held_r`<=1 and `held_gnt_r`<=`o_gnt`. The grant is frozen until acked.
  - `i_ack`=1 and `i_lock`=1: `held_r`<=1, `held_gnt_r`<=`o_gnt`, `ptr_r` unchanged.
  - `i_ack`=1 and `i_lock`=0: `held_r`<=0 and `ptr_r`<=(`o_gnt_enc`+1) mod N. Wrap from N-1 gives 0.
- `o_valid`=0: no state change. `i_ack` and `i_lock` are ignored.
- Invariant: `o_gnt` is one-hot or zero. `o_gnt_enc` always equals the index of the set bit of `o_gnt`.
- Protocol rule: a requester dropping `i_req` while granted and un-acked is illegal. The bench flags this with an assertion; RTL behaviour in that case is to keep presenting the held grant.
- N=1:
  - `ptr_r` stays 0.
  - `o_gnt` = `i_req` | (`held_r` & `held_gnt_r`).
  - `o_gnt_enc`=0.
- Reset asserted mid-transfer (held or locked): hold and lock are discarded immediately. The first cycle after deassertion arbitrates from index 0.

## Timing
- Request-to-grant latency: 0 cycles, combinational from `i_req`, `held_r`, `ptr_r`.
- Ack-to-rotation latency: 1 cycle. The pointer update is visible in the cycle after `i_ack`.
- Outputs depend only on flops and `i_req`. No combinational path exists from `i_ack` or `i_lock` to any output.
- Back-to-back acks sustain one grant per cycle. With all N requesting continuously, each requester wins exactly once every N cycles.
- Critical path: the N-bit wrap-around priority scan. Implementation uses a doubled request vector masked by `ptr_r`, or a thermometer mask, with no multi-cycle scan.

## Test plan
- Reset with `i_req`=0 -> `o_valid`=0, `o_gnt`=0, `o_gnt_enc`=0. Assert `arst_n`=0 mid-cycle -> state cleared without waiting for a clock edge.
- N=4, `i_req`=4'b1111, `i_ack`=1 every cycle -> `o_gnt` sequence 0001, 0010, 0100, 1000, 0001. `o_gnt_enc` sequence 0, 1, 2, 3, 0.
- N=4, `i_req`=4'b0100, `i_ack`=0 for 3 cycles, then `i_req`=4'b0101 with `ptr_r`=0 -> `o_gnt` stays 0100 until ack. The cycle after ack, `o_gnt`=0001 (pointer now 3, wrapped scan finds bit 0).
- N=4, `i_req`=4'b1010, `i_lock`=1 with `i_ack`=1 for 3 beats, then `i_lock`=0 with ack -> `o_gnt`=0010 for all 4 beats, then 1000.
- Reset asserted while grant 0100 is held un-acked, with `i_req`=4'b1100 after deassertion -> first grant is 0100 from `ptr_r`=0, with no stale hold. Repeat with `i_req`=4'b1001 -> 0001.
- N=1, `i_req`=1, `i_ack` toggling -> `o_gnt`=1 and `o_gnt_enc`=0 every cycle. Random N=5 soak with legal held requests -> one-hot invariant holds, and no requester waits more than 4 acked beats, excluding locked beats.

Source files
------------

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb
//  Purpose  : Round-robin arbiter producing a one-hot grant (plus its binary
//             index) for a downstream AND-OR mux. The grant is combinational
//             from the request vector, frozen while un-acked, and optionally
//             locked across multi-beat transfers. A registered priority
//             pointer rotates past each completed winner.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb #(
  parameter int N     = 4,
  parameter int W_ENC = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_lock,
  input  logic             i_ack,
  output logic             o_valid,
  output logic [N-1:0]     o_gnt,
  output logic [W_ENC-1:0] o_gnt_enc
);

  // Hold state: set while a grant is waiting for ack or locked for more beats.
  logic             held_q;
  logic             held_d;
  logic [N-1:0]     held_gnt_q;
  logic [N-1:0]     held_gnt_d;

  // Combinational arbitration results shared by every configuration.
  logic [N-1:0]     w_gnt;
  logic [W_ENC-1:0] w_enc;
  logic             w_valid;

  // A grant exists whenever something is held or anyone is requesting.
  assign w_valid = held_q | (|i_req);

  // One-hot to binary; OR-ing indices is exact because w_gnt is one-hot or 0.
  always_comb begin
    w_enc = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_enc = w_enc | W_ENC'(i);
      end
    end
  end

  // Next hold state: freeze the grant until acked, keep it while locked.
  always_comb begin
    held_d     = held_q;
    held_gnt_d = held_gnt_q;
    if (w_valid) begin
      if (!i_ack || i_lock) begin
        held_d     = 1'b1;
        held_gnt_d = w_gnt;
      end else begin
        held_d     = 1'b0;
      end
    end
  end

  // Hold registers; asynchronous reset discards any hold or lock at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      held_q     <= 1'b0;
      held_gnt_q <= '0;
    end else begin
      held_q     <= held_d;
      held_gnt_q <= held_gnt_d;
    end
  end

  generate
    if (N == 1) begin : g_single
      // Single requester: no pointer, the grant is the request or the hold.
      always_comb begin
        w_gnt = i_req | ({N{held_q}} & held_gnt_q);
      end
    end else begin : g_multi
      logic [W_ENC-1:0] ptr_q;
      logic [W_ENC-1:0] ptr_d;
      logic [31:0]      w_ptr_ext;
      logic [N-1:0]     w_mask;
      logic [N-1:0]     w_req_hi;
      logic [N-1:0]     w_pick_hi;
      logic [N-1:0]     w_pick_lo;

      assign w_ptr_ext = 32'(ptr_q);

      // Thermometer mask selecting indices at or above the priority pointer.
      always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
          w_mask[i] = (32'(i) >= w_ptr_ext);
        end
      end

      // Wrap-around scan: lowest set bit at/above ptr, else lowest set bit
      // overall. Isolating the lowest set bit keeps this a single carry chain.
      assign w_req_hi  = i_req & w_mask;
      assign w_pick_hi = w_req_hi & (~w_req_hi + N'(1));
      assign w_pick_lo = i_req & (~i_req + N'(1));

      // Held grant wins over fresh arbitration so nothing can preempt it.
      always_comb begin
        if (held_q) begin
          w_gnt = held_gnt_q;
        end else if (|w_req_hi) begin
          w_gnt = w_pick_hi;
        end else begin
          w_gnt = w_pick_lo;
        end
      end

      // Rotate priority one past the winner when its final beat is acked.
      always_comb begin
        ptr_d = ptr_q;
        if (w_valid && i_ack && !i_lock) begin
          if (32'(w_enc) == 32'(N - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = w_enc + W_ENC'(1);
          end
        end
      end

      // Priority pointer register.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end
  endgenerate

  assign o_valid   = w_valid;
  assign o_gnt     = w_gnt;
  assign o_gnt_enc = w_enc;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb
//  Purpose  : Scoreboard bench for rr_arb with N=4, N=5 and N=1 instances.
//             A reference model predicts each cycle's grant; a monitor pops
//             and compares, and also tracks protocol and wait bounds on N=5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n;

  logic [3:0] req4;  logic ack4, lock4, v4;  logic [3:0] g4;  logic [1:0] e4;
  logic [4:0] req5;  logic ack5, lock5, v5;  logic [4:0] g5;  logic [2:0] e5;
  logic [0:0] req1;  logic ack1, lock1, v1;  logic [0:0] g1;  logic [0:0] e1;

  rr_arb #(.N(4)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .i_req(req4), .i_lock(lock4), .i_ack(ack4),
    .o_valid(v4), .o_gnt(g4), .o_gnt_enc(e4)
  );
  rr_arb #(.N(5)) u_dut5 (
    .clk(clk), .arst_n(arst_n), .i_req(req5), .i_lock(lock5), .i_ack(ack5),
    .o_valid(v5), .o_gnt(g5), .o_gnt_enc(e5)
  );
  rr_arb #(.N(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .i_req(req1), .i_lock(lock1), .i_ack(ack1),
    .o_valid(v1), .o_gnt(g1), .o_gnt_enc(e1)
  );

  typedef struct {
    bit          valid;
    int          idx;
    bit          ack;
    bit          lock;
    bit          rst;
    logic [31:0] req;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t q1[$];
  exp_t le4, le5, le1;

  // Reference model state: priority index, hold flag, held winner.
  int m_n[3] = '{4, 5, 1};
  int m_ptr[3];
  int m_hidx[3];
  bit m_held[3];

  int n_checks = 0;
  int n_fail   = 0;

  // Next-cycle stimulus, applied by cyc() just after a falling edge.
  logic [3:0] nx_req4; logic nx_ack4, nx_lock4;
  logic [4:0] nx_req5; logic nx_ack5, nx_lock5;
  logic [0:0] nx_req1; logic nx_ack1, nx_lock1;
  logic       nx_rstn;

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0; m_hidx[d] = 0; m_held[d] = 1'b0;
    end
  endfunction

  // Highest priority is m_ptr; walk upward modulo n and take the first requester.
  function automatic exp_t model_eval(int d, logic [31:0] req, bit ack, bit lock, bit rst);
    exp_t e;
    int   j;
    e.valid = 1'b0; e.idx = 0; e.ack = ack; e.lock = lock; e.rst = rst; e.req = req;
    if (m_held[d]) begin
      e.valid = 1'b1;
      e.idx   = m_hidx[d];
    end else begin
      for (int k = 0; k < m_n[d]; k++) begin
        j = (m_ptr[d] + k) % m_n[d];
        if (!e.valid && req[j]) begin
          e.valid = 1'b1;
          e.idx   = j;
        end
      end
    end
    return e;
  endfunction

  function automatic void model_step(int d, exp_t e);
    if (e.rst || !e.valid) return;
    if (!e.ack || e.lock) begin
      m_held[d] = 1'b1;
      m_hidx[d] = e.idx;
    end else begin
      m_held[d] = 1'b0;
      m_ptr[d]  = (e.idx + 1) % m_n[d];
    end
  endfunction

  function automatic logic [31:0] exp_gnt(exp_t e);
    return e.valid ? (32'd1 << e.idx) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_enc(exp_t e);
    return e.valid ? 32'(e.idx) : 32'd0;
  endfunction

  // One clock of stimulus: drive inputs mid-cycle and queue the predictions.
  task automatic cyc();
    @(negedge clk);
    req4 = nx_req4; ack4 = nx_ack4; lock4 = nx_lock4;
    req5 = nx_req5; ack5 = nx_ack5; lock5 = nx_lock5;
    req1 = nx_req1; ack1 = nx_ack1; lock1 = nx_lock1;
    arst_n = nx_rstn;
    if (!arst_n) model_reset();
    le4 = model_eval(0, 32'(req4), ack4, lock4, !arst_n); q4.push_back(le4); model_step(0, le4);
    le5 = model_eval(1, 32'(req5), ack5, lock5, !arst_n); q5.push_back(le5); model_step(1, le5);
    le1 = model_eval(2, 32'(req1), ack1, lock1, !arst_n); q1.push_back(le1); model_step(2, le1);
  endtask

  task automatic idle_inputs();
    nx_req4 = '0; nx_ack4 = 1'b0; nx_lock4 = 1'b0;
    nx_req5 = '0; nx_ack5 = 1'b0; nx_lock5 = 1'b0;
    nx_req1 = '0; nx_ack1 = 1'b0; nx_lock1 = 1'b0;
  endtask

  task automatic run4(logic [3:0] r, bit a, bit l, int n);
    for (int i = 0; i < n; i++) begin
      nx_req4 = r; nx_ack4 = a; nx_lock4 = l;
      cyc();
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   wait5[5];
    bit   pend_v;
    int   pend_i;
    pend_v = 1'b0; pend_i = 0;
    for (int r = 0; r < 5; r++) wait5[r] = 0;
    forever begin
      @(negedge clk);
      #2;
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("valid4", 32'(v4), 32'(e.valid));
        chk("gnt4",   32'(g4), exp_gnt(e));
        chk("enc4",   32'(e4), exp_enc(e));
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("valid1", 32'(v1), 32'(e.valid));
        chk("gnt1",   32'(g1), exp_gnt(e));
        chk("enc1",   32'(e1), exp_enc(e));
      end
      if (q5.size() != 0) begin
        e = q5.pop_front();
        chk("valid5",  32'(v5), 32'(e.valid));
        chk("gnt5",    32'(g5), exp_gnt(e));
        chk("enc5",    32'(e5), exp_enc(e));
        chk("onehot5", 32'($countones(g5) <= 1), 32'd1);
        // A granted, un-acked requester must still be requesting.
        if (pend_v && !e.rst) chk("proto5_req_held", 32'(req5[pend_i]), 32'd1);
        pend_v = !e.rst && e.valid && !e.ack;
        pend_i = e.idx;
        // Count completed beats each waiting requester watches go elsewhere.
        if (e.rst) begin
          for (int r = 0; r < 5; r++) wait5[r] = 0;
        end else if (e.valid && e.ack && !e.lock) begin
          for (int r = 0; r < 5; r++) begin
            if (r == e.idx) begin
              chk("starve5", 32'(wait5[r] <= 4), 32'd1);
              wait5[r] = 0;
            end else if (e.req[r]) begin
              wait5[r]++;
            end else begin
              wait5[r] = 0;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stimulus
    arst_n  = 1'b0;
    req4 = '0; ack4 = 1'b0; lock4 = 1'b0;
    req5 = '0; ack5 = 1'b0; lock5 = 1'b0;
    req1 = '0; ack1 = 1'b0; lock1 = 1'b0;
    model_reset();
    idle_inputs();

    // Reset with no requests, then release.
    nx_rstn = 1'b0;
    cyc(); cyc();
    nx_rstn = 1'b1;
    cyc();

    // Full request with ack every cycle: strict rotation 0,1,2,3,0,1.
    run4(4'b1111, 1'b1, 1'b0, 6);
    run4(4'b0000, 1'b0, 1'b0, 1);

    // Bring pointer back to 0, then back-pressure a single requester.
    nx_rstn = 1'b0; cyc(); nx_rstn = 1'b1; cyc();
    run4(4'b0100, 1'b0, 1'b0, 3);
    run4(4'b0101, 1'b0, 1'b0, 2);   // higher priority arrival must not preempt
    run4(4'b0101, 1'b1, 1'b0, 1);   // ack requester 2, pointer -> 3
    run4(4'b0001, 1'b0, 1'b0, 1);   // wrapped scan finds bit 0
    run4(4'b0001, 1'b1, 1'b0, 1);

    // Locked multi-beat transfer: 0010 for 4 beats, then 1000.
    run4(4'b1010, 1'b1, 1'b1, 3);
    run4(4'b1010, 1'b1, 1'b0, 1);
    run4(4'b1000, 1'b1, 1'b0, 1);
    run4(4'b0000, 1'b0, 1'b0, 1);

    // Reset while 0100 is held un-acked; requests 1100 afterwards.
    run4(4'b0100, 1'b0, 1'b0, 2);
    nx_rstn = 1'b0; run4(4'b0100, 1'b0, 1'b0, 2);
    nx_rstn = 1'b1; run4(4'b1100, 1'b0, 1'b0, 1);
    run4(4'b1100, 1'b1, 1'b0, 1);

    // Same with 1001 after reset: no stale hold, grant 0001.
    run4(4'b0100, 1'b0, 1'b0, 2);
    nx_rstn = 1'b0; run4(4'b0100, 1'b0, 1'b0, 1);
    nx_rstn = 1'b1; run4(4'b1001, 1'b0, 1'b0, 1);
    run4(4'b1001, 1'b1, 1'b0, 1);
    run4(4'b0000, 1'b0, 1'b0, 1);

    // Single requester, ack toggling.
    idle_inputs();
    nx_req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nx_ack1 = ~nx_ack1;
      cyc();
    end

    // Random soak: N=5 follows the hold-until-acked protocol; N=4/N=1 are free.
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      nx_req4  = 4'($urandom);
      nx_ack4  = 1'(($urandom % 3) != 0);
      nx_lock4 = 1'(($urandom % 4) == 0);
      nx_req1  = 1'($urandom);
      nx_ack1  = 1'($urandom);
      nx_lock1 = 1'(($urandom % 4) == 0);
      nx_ack5  = 1'(($urandom % 3) != 0);
      nx_lock5 = 1'(($urandom % 4) == 0);
      cyc();
      if (le5.valid && le5.ack && !le5.lock) nx_req5[le5.idx] = 1'($urandom);
      for (int r = 0; r < 5; r++) begin
        if (!nx_req5[r] && (($urandom % 3) == 0)) nx_req5[r] = 1'b1;
      end
    end

    idle_inputs();
    cyc(); cyc(); cyc();
    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
